// File: rtl/mem_arbiter_pkg.sv
// Shared types, constants and helpers for the byte-wide RAM port arbiter.
// Holds the FSM/size encodings and the I/O window address compare.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_RSVD = 2'd3
    } size_e;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_LS = 1'b1
    } port_e;

    localparam logic [31:0] IO_BASE_DEFAULT = 32'h0003_0000;

    // Only the two UART registers sit behind the I/O buffer.
    function automatic logic is_io_addr(input logic [31:0] addr, input logic [31:0] base);
        return (addr == base) || (addr == base + 32'd4);
    endfunction

    // Reserved size code behaves as a word access.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size_e'(size))
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// Two-requester alternating grant (fetch vs load/store) with a blocking
// mask on the load/store side; remembers the last winner for fairness.
module mem_arb_grant
    import mem_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic if_req_i,
    input  logic ls_req_i,
    input  logic ls_block_i,
    output logic gnt_if_o,
    output logic gnt_ls_o
);

    port_e last_q, last_d;
    logic  ls_ok;

    always_comb begin
        gnt_if_o = 1'b0;
        gnt_ls_o = 1'b0;
        last_d   = last_q;
        ls_ok    = ls_req_i && !ls_block_i;
        if (en_i) begin
            // On a tie the side that did not win last time goes first.
            if (ls_ok && (!if_req_i || last_q == PORT_IF)) begin
                gnt_ls_o = 1'b1;
                last_d   = PORT_LS;
            end else if (if_req_i) begin
                gnt_if_o = 1'b1;
                last_d   = PORT_IF;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= PORT_IF;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Byte-serial sequencer for the shared RAM port: arbitrates fetch and
// load/store, splits accesses into byte cycles, reassembles little-endian data.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned       ADDR_W  = 32,
    parameter logic [ADDR_W-1:0] IO_BASE = ADDR_W'(IO_BASE_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rdy,
    input  logic              clear,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [1:0]        ls_size,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic              ls_done,
    output logic [31:0]       ls_rdata,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);

    state_e            state_q, state_d;
    port_e             port_q, port_d;
    logic              we_q, we_d;
    logic [2:0]        n_q, n_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [2:0]        idx_q, idx_d;
    logic              pend_q, pend_d;
    logic [31:0]       rbuf_q, rbuf_d;
    logic [31:0]       if_data_q, if_data_d;
    logic [31:0]       ls_rdata_q, ls_rdata_d;

    logic       grant_en;
    logic       gnt_if, gnt_ls;
    logic       ls_block;
    logic [2:0] addr_idx;

    assign grant_en = (state_q == ST_IDLE) && rdy && !clear;
    assign ls_block = ls_req && ls_we && io_buffer_full
                      && is_io_addr(32'(ls_addr), 32'(IO_BASE));

    mem_arb_grant u_grant (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (grant_en),
        .if_req_i   (if_req),
        .ls_req_i   (ls_req),
        .ls_block_i (ls_block),
        .gnt_if_o   (gnt_if),
        .gnt_ls_o   (gnt_ls)
    );

    // idx_q counts captured bytes; pend_q marks an address issued last cycle
    // with rdy high, so the byte being addressed now is idx_q + pend_q.
    assign addr_idx = idx_q + {2'b00, pend_q};

    always_comb begin
        state_d    = state_q;
        port_d     = port_q;
        we_d       = we_q;
        n_d        = n_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        idx_d      = idx_q;
        pend_d     = pend_q;
        rbuf_d     = rbuf_q;
        if_data_d  = if_data_q;
        ls_rdata_d = ls_rdata_q;
        mem_a      = '0;
        mem_dout   = '0;
        mem_wr     = 1'b0;
        if_done    = 1'b0;
        ls_done    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                idx_d  = '0;
                pend_d = 1'b0;
                if (gnt_ls) begin
                    port_d  = PORT_LS;
                    we_d    = ls_we;
                    n_d     = size_bytes(ls_size);
                    addr_d  = ls_addr;
                    wdata_d = ls_wdata;
                    rbuf_d  = '0;
                    state_d = ls_we ? ST_WR : ST_RD;
                end else if (gnt_if) begin
                    port_d  = PORT_IF;
                    we_d    = 1'b0;
                    n_d     = 3'd4;
                    addr_d  = if_addr;
                    wdata_d = '0;
                    rbuf_d  = '0;
                    state_d = ST_RD;
                end
            end

            ST_RD: begin
                if (addr_idx < n_q) begin
                    mem_a = addr_q + ADDR_W'(addr_idx);
                end
                if (clear) begin
                    state_d = ST_IDLE;
                end else if (rdy) begin
                    if (pend_q) begin
                        rbuf_d[{idx_q[1:0], 3'b000} +: 8] = mem_din;
                        idx_d = idx_q + 3'd1;
                    end
                    pend_d = (addr_idx < n_q);
                    if (addr_idx == n_q) begin
                        state_d = ST_DONE;
                    end
                end else begin
                    // A stalled capture cycle invalidates the in-flight byte.
                    pend_d = 1'b0;
                end
            end

            ST_WR: begin
                mem_a    = addr_q + ADDR_W'(idx_q);
                mem_dout = wdata_q[{idx_q[1:0], 3'b000} +: 8];
                if (rdy) begin
                    mem_wr = 1'b1;
                    idx_d  = idx_q + 3'd1;
                    if (idx_q + 3'd1 == n_q) begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                if (clear && !we_q) begin
                    state_d = ST_IDLE;
                end else if (rdy) begin
                    if (port_q == PORT_IF) begin
                        if_done   = 1'b1;
                        if_data_d = rbuf_q;
                    end else begin
                        ls_done = 1'b1;
                        if (!we_q) begin
                            ls_rdata_d = rbuf_q;
                        end
                    end
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign if_data  = if_done ? rbuf_q : if_data_q;
    assign ls_rdata = (ls_done && !we_q) ? rbuf_q : ls_rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            port_q     <= PORT_IF;
            we_q       <= 1'b0;
            n_q        <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            idx_q      <= '0;
            pend_q     <= 1'b0;
            rbuf_q     <= '0;
            if_data_q  <= '0;
            ls_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            port_q     <= port_d;
            we_q       <= we_d;
            n_q        <= n_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            idx_q      <= idx_d;
            pend_q     <= pend_d;
            rbuf_q     <= rbuf_d;
            if_data_q  <= if_data_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte RAM model whose read data
// arrives one cycle after the address.
module tb_mem_arbiter;

    logic        clk, rst_n, rdy, clear;
    logic        if_req, if_done, ls_req, ls_we, ls_done, mem_wr, io_buffer_full;
    logic [31:0] if_addr, if_data, ls_addr, ls_wdata, ls_rdata, mem_a;
    logic [1:0]  ls_size;
    logic [7:0]  mem_din, mem_dout;

    logic [7:0]  ram [0:262143];
    logic        ld_en;
    logic [17:0] ld_a;
    logic [7:0]  ld_d;
    int          wr_cnt;

    int total = 0;
    int bad   = 0;

    mem_arbiter #(.ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .clear(clear),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        mem_din <= ram[mem_a[17:0]];
        if (ld_en) ram[ld_a] <= ld_d;
        else if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
        if (!rst_n) wr_cnt <= 0;
        else if (mem_wr) wr_cnt <= wr_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        #2;
    endtask

    task automatic pre(input logic [17:0] a, input logic [7:0] d);
        ld_en = 1'b1; ld_a = a; ld_d = d;
        nxt();
        ld_en = 1'b0;
    endtask

    task automatic ls_go(input logic we, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        ls_we = we; ls_size = sz; ls_addr = a; ls_wdata = wd; ls_req = 1'b1;
    endtask

    // Cycles advanced until the port's done is seen; -1 if the budget expires.
    task automatic wait_done(input bit port_if, output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            nxt();
            smp();
            if ((port_if && if_done) || (!port_if && ls_done)) begin
                n = i;
                break;
            end
        end
    endtask

    logic [17:0] pa [12] = '{18'h40, 18'h100, 18'h101, 18'h102, 18'h103, 18'h206,
                             18'h400, 18'h401, 18'h402, 18'h403, 18'h3FFFF, 18'h0};
    logic [7:0]  pd [12] = '{8'h9A, 8'h13, 8'h05, 8'h10, 8'h00, 8'h77,
                             8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h12, 8'h34};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

    initial begin
        int n;
        int wc;
        int cnt;
        rst_n = 1'b0; rdy = 1'b1; clear = 1'b0; io_buffer_full = 1'b0;
        if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_we = 1'b0; ls_size = '0;
        ls_addr = '0; ls_wdata = '0; ld_en = 1'b0; ld_a = '0; ld_d = '0;
        for (int i = 0; i < 12; i++) pre(pa[i], pd[i]);

        smp();
        chk("rst_if_done", 32'(if_done), 0);
        chk("rst_ls_done", 32'(ls_done), 0);
        chk("rst_mem_wr", 32'(mem_wr), 0);
        chk("rst_mem_a", mem_a, 0);
        chk("rst_mem_dout", 32'(mem_dout), 0);
        chk("rst_if_data", if_data, 0);
        chk("rst_ls_rdata", ls_rdata, 0);

        // Both requesters pending out of reset: LS wins the first tie.
        if_req = 1'b1; if_addr = 32'h100;
        ls_go(1'b0, 2'd0, 32'h40, 32'h0);
        nxt(); rst_n = 1'b1; smp();
        nxt(); smp();
        chk("tie1_ls_first", mem_a, 32'h40);
        chk("tie1_rd_no_wr", 32'(mem_wr), 0);
        wait_done(1'b0, n);
        chk("tie1_ls_lat", n, 2);
        chk("tie1_ls_rdata", ls_rdata, 32'h0000009A);
        nxt(); ls_req = 1'b0; smp();
        for (int k = 0; k < 4; k++) begin
            nxt(); smp();
            chk("fetch_addr", mem_a, 32'h100 + k);
        end
        wait_done(1'b1, n);
        chk("fetch_lat", n, 2);
        chk("fetch_data", if_data, 32'h00100513);

        // Second tie after an IF grant: LS again.
        nxt(); ls_req = 1'b1; smp();
        nxt(); smp();
        chk("tie2_ls_first", mem_a, 32'h40);
        wait_done(1'b0, n);
        chk("tie2_ls_lat", n, 2);
        nxt(); ls_req = 1'b0; smp();
        wait_done(1'b1, n);
        chk("tie2_if_lat", n, 6);
        nxt(); if_req = 1'b0; smp();

        // Half-word store.
        nxt(); ls_go(1'b1, 2'd1, 32'h204, 32'hDEADBEEF); smp();
        nxt(); smp();
        chk("hst_wr0", 32'(mem_wr), 1);
        chk("hst_a0", mem_a, 32'h204);
        chk("hst_d0", 32'(mem_dout), 32'hEF);
        nxt(); smp();
        chk("hst_a1", mem_a, 32'h205);
        chk("hst_d1", 32'(mem_dout), 32'hBE);
        nxt(); smp();
        chk("hst_done", 32'(ls_done), 1);
        chk("hst_done_no_wr", 32'(mem_wr), 0);

        // Tie after an LS grant: IF goes first.
        nxt(); ls_go(1'b0, 2'd0, 32'h40, 32'h0); if_req = 1'b1; if_addr = 32'h100; smp();
        nxt(); smp();
        chk("tie3_if_first", mem_a, 32'h100);
        chk("hst_mem", {8'h0, ram[18'h206], ram[18'h205], ram[18'h204]}, 32'h0077BEEF);
        wait_done(1'b1, n);
        chk("tie3_if_lat", n, 5);
        nxt(); if_req = 1'b0; smp();
        wait_done(1'b0, n);
        chk("tie3_ls_lat", n, 3);
        nxt(); ls_req = 1'b0; smp();

        // I/O store held off while the buffer is full.
        nxt(); ls_go(1'b1, 2'd0, 32'h30000, 32'h41); io_buffer_full = 1'b1; smp();
        wc = wr_cnt;
        for (int i = 0; i < 4; i++) begin nxt(); smp(); end
        nxt(); io_buffer_full = 1'b0; smp();
        chk("io_held_writes", wr_cnt - wc, 0);
        chk("io_idle_no_wr", 32'(mem_wr), 0);
        nxt(); smp();
        chk("io_wr", 32'(mem_wr), 1);
        chk("io_a", mem_a, 32'h30000);
        chk("io_d", 32'(mem_dout), 32'h41);
        wait_done(1'b0, n);
        chk("io_lat", n, 1);
        nxt(); ls_req = 1'b0; smp();

        // IO_BASE+4 is blocked too; IO_BASE+8 is ordinary memory.
        nxt(); ls_go(1'b1, 2'd0, 32'h30004, 32'h42); io_buffer_full = 1'b1; smp();
        nxt(); smp();
        chk("io4_blocked", 32'(mem_wr), 0);
        nxt(); ls_addr = 32'h30008; smp();
        nxt(); smp();
        chk("io8_wr", 32'(mem_wr), 1);
        chk("io8_a", mem_a, 32'h30008);
        wait_done(1'b0, n);
        chk("io8_lat", n, 1);
        nxt(); ls_req = 1'b0; io_buffer_full = 1'b0; smp();

        // clear during byte 2 of a fetch.
        nxt(); if_req = 1'b1; if_addr = 32'h100; smp();
        nxt(); smp();
        nxt(); smp();
        nxt(); clear = 1'b1; smp();
        chk("clrf_byte2_a", mem_a, 32'h102);
        nxt(); clear = 1'b0; if_req = 1'b0; smp();
        chk("clrf_idle_a", mem_a, 0);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            nxt(); smp();
            if (if_done) cnt++;
        end
        chk("clrf_no_done", cnt, 0);

        // clear during a word store does not abort it.
        nxt(); ls_go(1'b1, 2'd2, 32'h300, 32'h11223344); smp();
        nxt(); smp();
        nxt(); clear = 1'b1; smp();
        chk("clrs_wr", 32'(mem_wr), 1);
        nxt(); clear = 1'b0; smp();
        wait_done(1'b0, n);
        chk("clrs_lat", n, 2);
        nxt(); ls_req = 1'b0; smp();
        chk("clrs_mem", {ram[18'h303], ram[18'h302], ram[18'h301], ram[18'h300]}, 32'h11223344);

        // rdy low for 3 cycles in the middle of a word load.
        nxt(); ls_go(1'b0, 2'd2, 32'h400, 32'h0); smp();
        nxt(); smp();
        nxt(); smp();
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            nxt(); rdy = 1'b0; smp();
            if (mem_wr || ls_done) cnt++;
        end
        chk("pause_quiet", cnt, 0);
        nxt(); rdy = 1'b1; smp();
        wait_done(1'b0, n);
        chk("pause_lat", n, 4);
        chk("pause_rdata", ls_rdata, 32'hD4C3B2A1);
        nxt(); ls_req = 1'b0; smp();

        // rdy low on a store cycle suppresses the write strobe.
        nxt(); ls_go(1'b1, 2'd0, 32'h500, 32'h5A); smp();
        nxt(); rdy = 1'b0; smp();
        chk("pst_no_wr", 32'(mem_wr), 0);
        nxt(); rdy = 1'b1; smp();
        chk("pst_wr", 32'(mem_wr), 1);
        chk("pst_a", mem_a, 32'h500);
        nxt(); smp();
        chk("pst_done", 32'(ls_done), 1);
        nxt(); ls_req = 1'b0; smp();

        // Half load across the top of the address space.
        nxt(); ls_go(1'b0, 2'd1, 32'hFFFF_FFFF, 32'h0); smp();
        nxt(); smp();
        chk("wrap_a0", mem_a, 32'hFFFF_FFFF);
        nxt(); smp();
        chk("wrap_a1", mem_a, 32'h0);
        wait_done(1'b0, n);
        chk("wrap_lat", n, 2);
        chk("wrap_rdata", ls_rdata, 32'h00003412);
        nxt(); ls_req = 1'b0; smp();

        // Reserved size code loads a full word.
        nxt(); ls_go(1'b0, 2'd3, 32'h400, 32'h0); smp();
        wait_done(1'b0, n);
        chk("sz3_lat", n, 6);
        chk("sz3_rdata", ls_rdata, 32'hD4C3B2A1);
        nxt(); ls_req = 1'b0; smp();
        chk("if_data_hold", if_data, 32'h00100513);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequencer and arbiter for the single byte-wide RAM port, shared between instruction fetch (4-byte reads) and the load/store execution unit fed by the LSB (1/2/4-byte loads and stores).
- Serialises each request into byte cycles and reassembles little-endian read data.
- Enforces the I/O-buffer backpressure rule on stores to I/O addresses.
- Honours the global rdy pause and the pipeline clear.

Parameters:
- ADDR_W, 32, address width for requests and mem_a.
- IO_BASE, 32'h30000, I/O window base. Addresses IO_BASE and IO_BASE+4 are I/O.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- rdy  in  1  global enable; low freezes the block.
- clear  in  1  misprediction flush.
- if_req  in  1  fetch request; held until if_done.
- if_addr  in  ADDR_W  fetch address.
- if_done  out  1  one-cycle pulse; if_data valid.
- if_data  out  32  fetched word.
- ls_req  in  1  load/store request; held until ls_done.
- ls_we  in  1  1 = store, 0 = load.
- ls_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal and treated as word.
- ls_addr  in  ADDR_W  access address.
- ls_wdata  in  32  store data; low bytes used.
- ls_done  out  1  one-cycle pulse.
- ls_rdata  out  32  load data, zero-extended raw bytes. Sign extension is done downstream.
- mem_din  in  8  RAM read byte.
- mem_dout  out  8  RAM write byte.
- mem_a  out  ADDR_W  RAM byte address.
- mem_wr  out  1  RAM write strobe.
- io_buffer_full  in  1  UART buffer full.

Behaviour:
- Reset: all outputs 0; FSM = IDLE; last_grant = IF, so LS wins the first tie.
- RAM timing: mem_din in cycle c holds the byte addressed by mem_a in cycle c-1. Writes take effect in the cycle mem_wr=1.
- States:
  - IDLE: samples requests.
  - RD: byte reads.
  - WR: byte writes.
  - DONE: pulses done, returns to IDLE.
- Arbitration in IDLE (cycle T):
  - Only one requester active: it is granted.
  - Both active: the one not granted last is granted (alternation).
  - LS store whose address is IO_BASE or IO_BASE+4 while io_buffer_full=1: not granted. IF may be granted instead if pending.
- Read, n bytes (n=4 for IF; 1/2/4 for LS):
  - mem_a = addr+k in cycle T+1+k, mem_wr=0.
  - Byte k captured into result[8k+7:8k] at the end of cycle T+2+k.
  - done=1 with data in cycle T+2+n. For a word fetch that is T+6.
- Write, n bytes:
  - Cycle T+1+k: mem_a = addr+k, mem_dout = wdata[8k+7:8k], mem_wr=1.
  - ls_done in cycle T+1+n.
- Handshake:
  - done is high for exactly one cycle.
  - The FSM is in IDLE the next cycle.
  - Requesters must drop req in that IDLE cycle. A req still high there is treated as a new request.
- Data outputs: if_data and ls_rdata hold their values until the next done of the same port. Unused upper bytes of ls_rdata are 0.
- Between transactions: mem_wr=0, mem_a=0, mem_dout=0.
- Address increment: modulo 2^ADDR_W (wraps).
- clear=1 (synchronous priority over everything except reset):
  - Aborts any IF read or LS read. No done is pulsed; FSM returns to IDLE next cycle.
  - An LS store in progress is NOT aborted; it completes and pulses ls_done.
  - clear in IDLE blocks grants that cycle.
- rdy=0:
  - FSM, counters and captured bytes hold; mem_wr forced 0; done outputs forced 0.
  - A pending done is delivered after rdy returns.
  - A byte is captured only when rdy was 1 in both its address cycle and its capture cycle. Otherwise that address is re-driven once rdy returns.
- Reset asserted mid-transaction: immediate return to the reset state. A partial store is left partial; this is acceptable.

Decomposition:
- Shared package holds:
  - state encodings;
  - ls_size encodings;
  - IO_BASE;
  - the I/O-address compare as a constant function.
- One natural sub-module, mem_arb_grant: a 2-requester alternating grant with a masked-request input for the io_buffer_full rule. It is combinational grant logic plus the last_grant register.
- Byte sequencing stays in mem_arbiter.

Test Plan:
- Word fetch:
  - Stimulus: if_req, if_addr=0x100; RAM bytes 0x13,0x05,0x10,0x00.
  - Response: mem_a = 0x100..0x103 in T+1..T+4; if_done in T+6 with if_data=0x00100513.
- Half-word store:
  - Stimulus: ls_we=1, ls_size=1, ls_addr=0x204, ls_wdata=0xDEADBEEF.
  - Response: writes 0xEF at 0x204 and 0xBE at 0x205; ls_done at T+3; memory 0x206 untouched.
- Contention:
  - Stimulus: if_req and ls_req (byte load at 0x40 = 0x9A) both high from reset.
  - Response: LS served first; ls_rdata=0x0000009A; IF granted in the next IDLE; alternation confirmed on a second tie.
- I/O backpressure:
  - Stimulus: store byte 0x41 to 0x30000 with io_buffer_full=1 for 5 cycles.
  - Response: mem_wr stays 0; store is issued the cycle after IDLE sees io_buffer_full=0.
- clear:
  - Stimulus: clear asserted during byte 2 of a fetch.
  - Response: no if_done; IDLE next cycle.
  - Stimulus: clear asserted during a word store.
  - Response: all 4 bytes are still written and ls_done pulses.
- rdy pause:
  - Stimulus: rdy=0 for 3 cycles in the middle of a word load.
  - Response: mem_wr=0 during the pause; load result is correct; ls_done is delayed by the pause plus the re-driven byte.
